ps2_key_decoder: RTL
====================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65000, frame-abort idle time in pclk cycles (1 ms at 65 MHz).
REQ-002 SHALL have port pclk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ps2_clk  input  1  raw keyboard clock, asynchronous.
REQ-005 SHALL have port ps2_data  input  1  raw keyboard data, asynchronous.
REQ-006 SHALL have port keycode  output  8  scan code of the currently held key; 0x00 when none is held.
REQ-007 SHALL have port key  output  6  one-hot, one-cycle key event: [0] UP, [1] DOWN, [2] LEFT, [3] RIGHT, [4] ENTER, [5] ESC.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse on a parity, start or stop error, or on a timeout.

Function
REQ-009 SHALL pass ps2_clk and ps2_data through two-flop synchronizers.
REQ-010 SHALL sample ps2_data on each synchronized ps2_clk falling edge (1 to 0 across consecutive pclk samples).
REQ-011 Frame FSM states: IDLE, SHIFT, CHECK.
- IDLE -> SHIFT on a falling edge with data=0 (start bit).
- In IDLE, a falling edge with data=1 is ignored.
REQ-012 In SHIFT, the block SHALL collect 10 further bits: 8 data bits LSB first, odd parity, then stop; after the 10th bit it SHALL go to CHECK.
REQ-013 In CHECK, a frame is valid if data XOR parity has odd weight and stop=1; the FSM SHALL return to IDLE after exactly one cycle.
REQ-014 An invalid frame SHALL pulse frame_err for one cycle, discard the byte, and clear the E0/F0 prefix flags.
REQ-015 In SHIFT, if TIMEOUT_CYCLES pclk cycles pass with no falling edge, the block SHALL pulse frame_err, discard partial bits, clear the prefix flags, and go to IDLE.
REQ-016 A valid byte 0xE0 SHALL set ext_flag; 0xF0 SHALL set brk_flag; neither produces output.
REQ-017 Any other valid byte completes a code; ext_flag and brk_flag SHALL clear in the same cycle.
REQ-018 Key mapping: UP=E0 75, DOWN=E0 72, LEFT=E0 6B, RIGHT=E0 74, ENTER=5A (no E0), ESC=76 (no E0); ext_flag must match exactly.
REQ-019 Make (brk_flag=0) of a mapped key not already held SHALL:
- pulse its key bit for exactly one cycle, on the cycle after CHECK;
- set its held bit.
REQ-020 Typematic repeats of a held key SHALL NOT pulse key; keycode SHALL stay unchanged.
REQ-021 A break code SHALL clear that key's held bit; key SHALL stay 0.
REQ-022 Any make, mapped or not, SHALL load keycode with the code byte (prefix not included), registered in the same cycle as the key pulse.
REQ-023 A break whose byte equals keycode SHALL set keycode to 0x00; a break for any other key SHALL leave keycode unchanged.
REQ-024 key SHALL never have more than one bit set; a completed code produces at most one pulse.
REQ-025 Latency: the key pulse is 2 pclk cycles after the falling edge on which the stop bit is sampled.

Reset
REQ-026 While rst=0 at a clock edge, the block SHALL force:
- FSM to IDLE; bit counter, shift register and timeout counter to 0;
- ext_flag, brk_flag and all held bits to 0;
- keycode=0x00, key=6'b000000, frame_err=0.
REQ-027 Reset asserted mid-frame SHALL discard the partial frame; the first frame after release SHALL decode normally.

Verification
REQ-028 Frame 0x5A, correct parity -> key=6'b010000 for exactly 1 cycle; keycode=0x5A.
REQ-029 Frames E0,6B then E0,6B again then E0,F0,6B:
- key=6'b000100 exactly once;
- keycode=0x6B until the break, then 0x00.
REQ-030 Frame 0x75 without E0 -> key stays 0; keycode=0x75.
REQ-031 Frame 0x76 with parity bit inverted -> frame_err one-cycle pulse; key=0; keycode unchanged; the next valid frame decodes.
REQ-032 Stop after 5 bits for more than TIMEOUT_CYCLES -> frame_err pulse; a following valid E0,74 frame -> key=6'b001000.
REQ-033 rst=0 for 1 cycle during bit 4 of a frame -> all outputs 0; a following frame 0x5A -> key=6'b010000.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and scan-code decoder for the navigation keys.
// Emits one-cycle key events, the currently held scan code, and frame error pulses.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic [5:0] key,
    output logic       frame_err
);

    localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned FRAME_W = 10;
    localparam int unsigned BCNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic                 ps2_clk_meta;
    logic                 ps2_clk_sync;
    logic                 ps2_clk_prev;
    logic                 ps2_data_meta;
    logic                 ps2_data_sync;
    logic [BCNT_W-1:0]    bit_cnt;
    logic [FRAME_W-1:0]   shift_reg;
    logic [TMO_W-1:0]     tmo_cnt;
    logic                 ext_flag;
    logic                 brk_flag;
    logic [5:0]           held;
    logic                 fall_c;
    logic                 timeout_c;
    logic                 frame_valid_c;
    logic [7:0]           code_c;
    logic [5:0]           map_c;

    // Synchronizers carry no reset; they settle while rst is held.
    always_ff @(posedge pclk) begin
        ps2_clk_meta  <= ps2_clk;
        ps2_clk_sync  <= ps2_clk_meta;
        ps2_clk_prev  <= ps2_clk_sync;
        ps2_data_meta <= ps2_data;
        ps2_data_sync <= ps2_data_meta;
    end

    assign fall_c        = ps2_clk_prev & ~ps2_clk_sync;
    assign code_c        = shift_reg[7:0];
    assign frame_valid_c = (^shift_reg[8:0]) & shift_reg[9];

    // Scan code to key index; the E0 prefix must match exactly.
    always_comb begin
        map_c = '0;
        if (ext_flag) begin
            case (code_c)
                8'h75:   map_c = 6'b000001;
                8'h72:   map_c = 6'b000010;
                8'h6B:   map_c = 6'b000100;
                8'h74:   map_c = 6'b001000;
                default: map_c = '0;
            endcase
        end else begin
            case (code_c)
                8'h5A:   map_c = 6'b010000;
                8'h76:   map_c = 6'b100000;
                default: map_c = '0;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        timeout_c = 1'b0;
        case (state)
            IDLE: begin
                if (fall_c && !ps2_data_sync) state_nx = SHIFT;
            end
            SHIFT: begin
                if (fall_c) begin
                    if (bit_cnt == BCNT_W'(FRAME_W - 1)) state_nx = CHECK;
                end else if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_nx  = IDLE;
                    timeout_c = 1'b1;
                end
            end
            CHECK:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Frame datapath, prefix tracking and key event generation.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
            tmo_cnt   <= '0;
            ext_flag  <= 1'b0;
            brk_flag  <= 1'b0;
            held      <= '0;
            keycode   <= '0;
            key       <= '0;
            frame_err <= 1'b0;
        end else begin
            key       <= '0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    bit_cnt <= '0;
                    tmo_cnt <= '0;
                end
                SHIFT: begin
                    if (fall_c) begin
                        shift_reg <= {ps2_data_sync, shift_reg[FRAME_W-1:1]};
                        bit_cnt   <= bit_cnt + BCNT_W'(1);
                        tmo_cnt   <= '0;
                    end else if (timeout_c) begin
                        frame_err <= 1'b1;
                        ext_flag  <= 1'b0;
                        brk_flag  <= 1'b0;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                CHECK: begin
                    bit_cnt <= '0;
                    if (!frame_valid_c) begin
                        frame_err <= 1'b1;
                        ext_flag  <= 1'b0;
                        brk_flag  <= 1'b0;
                    end else if (code_c == 8'hE0) begin
                        ext_flag <= 1'b1;
                    end else if (code_c == 8'hF0) begin
                        brk_flag <= 1'b1;
                    end else begin
                        ext_flag <= 1'b0;
                        brk_flag <= 1'b0;
                        if (!brk_flag) begin
                            keycode <= code_c;
                            key     <= map_c & ~held;
                            held    <= held | map_c;
                        end else begin
                            held <= held & ~map_c;
                            if (code_c == keycode) keycode <= '0;
                        end
                    end
                end
                default: bit_cnt <= '0;
            endcase
        end
    end

endmodule
